truth_table_scanner: RTL and testbench

Sequential stimulus and capture stage that sits directly upstream of, and wraps, a 4-input combinational function block such as the 8:1-mux-based function unit. On a start pulse it drives all 16 input combinations onto the block's a, b, c, d inputs in ascending order. It samples the returned f after a programmable settle time and assembles a 16-bit truth table. It also counts minterms and checks the captured table against an expected pattern.

---
 rtl/truth_table_scanner.sv | 123 ++++++++++++
 tb/tb_truth_table_scanner.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/truth_table_scanner.sv
// Sweeps all 16 {a,b,c,d} vectors into a 4-input combinational block, captures f after a
// programmable settle delay, and scores the captured truth table against a golden pattern.
module truth_table_scanner #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] expected,
  input  logic        f_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic [4:0]  ones_count,
  output logic [4:0]  mismatch_count,
  output logic        match
);

  localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_e;

  state_e      state_q;
  logic [3:0]  idx_q;
  logic [3:0]  settle_q;
  logic [3:0]  vec_q;
  logic        busy_q;
  logic        done_q;
  logic        match_q;
  logic [15:0] tableOut_q;
  logic [15:0] tableOut_d;
  logic [4:0]  onesCount_q;
  logic [4:0]  onesCount_d;
  logic [4:0]  mismCount_q;
  logic [4:0]  mismCount_d;

  // Result registers as they look once the bit at the current index is folded in.
  always_comb begin
    tableOut_d        = tableOut_q;
    tableOut_d[idx_q] = f_in;
    onesCount_d       = onesCount_q + {4'd0, f_in};
    mismCount_d       = mismCount_q + {4'd0, f_in ^ expected[idx_q]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      settle_q    <= 4'd0;
      vec_q       <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      match_q     <= 1'b0;
      tableOut_q  <= 16'd0;
      onesCount_q <= 5'd0;
      mismCount_q <= 5'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= DRIVE;
            idx_q       <= 4'd0;
            settle_q    <= 4'd0;
            vec_q       <= 4'd0;
            busy_q      <= 1'b1;
            match_q     <= 1'b0;
            tableOut_q  <= 16'd0;
            onesCount_q <= 5'd0;
            mismCount_q <= 5'd0;
          end
        end
        DRIVE: begin
          if (settle_q == SettleLast) begin
            state_q  <= SAMPLE;
            settle_q <= 4'd0;
          end else begin
            settle_q <= settle_q + 4'd1;
          end
        end
        SAMPLE: begin
          tableOut_q  <= tableOut_d;
          onesCount_q <= onesCount_d;
          mismCount_q <= mismCount_d;
          if (idx_q == 4'd15) begin
            // match is computed from the final count so it is valid in the DONE cycle.
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            match_q <= (mismCount_d == 5'd0);
          end else begin
            state_q  <= DRIVE;
            idx_q    <= idx_q + 4'd1;
            vec_q    <= idx_q + 4'd1;
            settle_q <= 4'd0;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign a              = vec_q[3];
  assign b              = vec_q[2];
  assign c              = vec_q[1];
  assign d              = vec_q[0];
  assign busy           = busy_q;
  assign done           = done_q;
  assign table_out      = tableOut_q;
  assign ones_count     = onesCount_q;
  assign mismatch_count = mismCount_q;
  assign match          = match_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench for truth_table_scanner: two instances (SETTLE 1 and 3) each driving a
// table-lookup function block; expectations come from popcounts of the chosen tables.
module tb_truth_table_scanner;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] tbl;
    logic [4:0]  ones;
    logic [4:0]  mism;
    logic        match;
    int          doneCyc;
  } exp_t;

  exp_t sbq0[$];
  exp_t sbq1[$];

  logic        startS [2];
  logic [15:0] expS   [2];
  logic [15:0] funcS  [2];
  wire         fS     [2];
  wire         aS     [2];
  wire         bS     [2];
  wire         cS     [2];
  wire         dS     [2];
  wire         busyS  [2];
  wire         doneS  [2];
  wire  [15:0] tblS   [2];
  wire  [4:0]  onesS  [2];
  wire  [4:0]  mismS  [2];
  wire         matchS [2];

  // The downstream function block is modelled as a 16-entry lookup on {a,b,c,d}.
  assign fS[0] = funcS[0][{aS[0], bS[0], cS[0], dS[0]}];
  assign fS[1] = funcS[1][{aS[1], bS[1], cS[1], dS[1]}];

  truth_table_scanner #(.SETTLE(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(startS[0]), .expected(expS[0]), .f_in(fS[0]),
    .a(aS[0]), .b(bS[0]), .c(cS[0]), .d(dS[0]), .busy(busyS[0]), .done(doneS[0]),
    .table_out(tblS[0]), .ones_count(onesS[0]), .mismatch_count(mismS[0]), .match(matchS[0])
  );

  truth_table_scanner #(.SETTLE(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(startS[1]), .expected(expS[1]), .f_in(fS[1]),
    .a(aS[1]), .b(bS[1]), .c(cS[1]), .d(dS[1]), .busy(busyS[1]), .done(doneS[1]),
    .table_out(tblS[1]), .ones_count(onesS[1]), .mismatch_count(mismS[1]), .match(matchS[1])
  );

  function automatic int settleOf(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [3:0] vecOf(input int i);
    return {aS[i], bS[i], cS[i], dS[i]};
  endfunction

  function automatic logic [32:0] outsOf(input int i);
    return {vecOf(i), busyS[i], doneS[i], tblS[i], onesS[i], mismS[i], matchS[i]};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Monitor: every done pulse pops the oldest expectation for that instance.
  always @(negedge clk) begin
    exp_t e;
    logic got;
    for (int i = 0; i < 2; i++) begin
      if (doneS[i] === 1'b1) begin
        got = 1'b0;
        if (i == 0 && sbq0.size() > 0) begin e = sbq0.pop_front(); got = 1'b1; end
        else if (i == 1 && sbq1.size() > 0) begin e = sbq1.pop_front(); got = 1'b1; end
        if (!got) begin
          checkOutput($sformatf("dut%0d unexpected done", i), 64'd1, 64'd0);
        end else begin
          checkOutput($sformatf("dut%0d table_out", i), 64'(tblS[i]), 64'(e.tbl));
          checkOutput($sformatf("dut%0d ones_count", i), 64'(onesS[i]), 64'(e.ones));
          checkOutput($sformatf("dut%0d mismatch_count", i), 64'(mismS[i]), 64'(e.mism));
          checkOutput($sformatf("dut%0d match", i), 64'(matchS[i]), 64'(e.match));
          checkOutput($sformatf("dut%0d done cycle", i), 64'(cyc), 64'(e.doneCyc));
        end
      end
    end
  end

  // One scan on instance i. extraAt injects a start pulse mid-scan; resetAt aborts with reset.
  task automatic applyStimulus(input int i, input logic [15:0] func, input logic [15:0] expv,
                               input int extraAt, input int resetAt);
    exp_t e;
    int   s;
    int   n;
    s = settleOf(i);
    n = 16 * (s + 1);
    funcS[i] = func;
    expS[i]  = expv;
    e.tbl    = func;
    e.ones   = 5'($countones(func));
    e.mism   = 5'($countones(func ^ expv));
    e.match  = (e.mism == 5'd0);
    @(negedge clk) startS[i] = 1'b1;
    @(negedge clk) startS[i] = 1'b0;
    e.doneCyc = cyc + n;
    if (resetAt < 0) begin
      if (i == 0) sbq0.push_back(e); else sbq1.push_back(e);
    end
    for (int j = 0; j <= n; j++) begin
      if (j < n)
        checkOutput($sformatf("dut%0d busy/vector at step %0d", i, j),
                    64'({busyS[i], vecOf(i)}), 64'({1'b1, 4'(j / (s + 1))}));
      else
        checkOutput($sformatf("dut%0d busy/vector at done", i),
                    64'({busyS[i], vecOf(i)}), 64'({1'b0, 4'hF}));
      if (j == extraAt) startS[i] = 1'b1;
      if (j == extraAt + 1) startS[i] = 1'b0;
      if (j == resetAt) begin
        #2 rst_n = 1'b0;
        #1 checkOutput($sformatf("dut%0d outputs on async reset", i), 64'(outsOf(i)), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
          @(negedge clk);
          checkOutput($sformatf("dut%0d outputs idle after abort", i), 64'(outsOf(i)), 64'd0);
        end
        return;
      end
      @(negedge clk);
    end
    if (i == 0) begin
      checkOutput("dut0 done seen", 64'(sbq0.size()), 64'd0);
      sbq0.delete();
    end else begin
      checkOutput("dut1 done seen", 64'(sbq1.size()), 64'd0);
      sbq1.delete();
    end
    repeat (3) @(negedge clk);
    checkOutput($sformatf("dut%0d held state", i),
                64'({busyS[i], doneS[i], vecOf(i), tblS[i], matchS[i]}),
                64'({1'b0, 1'b0, 4'hF, func, e.match}));
  endtask

  initial begin
    logic [15:0] f;
    logic [15:0] x;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      startS[i] = 1'b0;
      expS[i]   = 16'd0;
      funcS[i]  = 16'd0;
    end
    repeat (3) @(negedge clk);
    checkOutput("dut0 outputs in reset", 64'(outsOf(0)), 64'd0);
    checkOutput("dut1 outputs in reset", 64'(outsOf(1)), 64'd0);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      checkOutput("dut0 idle outputs", 64'(outsOf(0)), 64'd0);
      checkOutput("dut1 idle outputs", 64'(outsOf(1)), 64'd0);
    end

    applyStimulus(0, 16'h73F0, 16'h73F0, -1, -1);
    applyStimulus(0, 16'h73F0, 16'h73F1, -1, -1);
    applyStimulus(0, 16'h73F0, 16'h8C0F, -1, -1);
    applyStimulus(1, 16'hFFFF, 16'hFFFF, -1, -1);
    applyStimulus(0, 16'h73F0, 16'h73F0, 9, -1);
    applyStimulus(0, 16'h0F35, 16'h0F34, -1, -1);
    applyStimulus(0, 16'h73F0, 16'h73F0, -1, 14);
    applyStimulus(0, 16'h73F0, 16'h73F0, -1, -1);

    for (int k = 0; k < 6; k++) begin
      f = 16'($urandom);
      case ($urandom_range(0, 2))
        0:       x = f;
        1:       x = f ^ (16'h0001 << $urandom_range(0, 15));
        default: x = 16'($urandom);
      endcase
      applyStimulus(k % 2, f, x, -1, -1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
